// File: rtl/jk_pkg.sv
// Shared definitions for the JK register bank: operating modes, the JK
// action encoding, and the single-bit next-state rule used by both the
// cells and the bank's change detector.
package jk_pkg;

   typedef enum logic [1:0] {
      MODE_JK   = 2'd0,
      MODE_LOAD = 2'd1,
      MODE_UP   = 2'd2,
      MODE_DOWN = 2'd3
   } mode_e;

   // JK action encoding, indexed as {j, k}
   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TOG  = 2'b11;

   function automatic logic jk_next(input logic j, input logic k, input logic q);
      logic r;
      r = q;
      case ({j, k})
         JK_HOLD: r = q;
         JK_CLR:  r = 1'b0;
         JK_SET:  r = 1'b1;
         JK_TOG:  r = ~q;
         default: r = q;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// One JK flip-flop with enable and an asynchronous active-low reset to a
// per-instance reset value.
module jk_ff_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic n_rst,
   input  logic rst_val,
   input  logic en,
   input  logic j,
   input  logic k,
   output logic q
);

   logic q_q;

   // State bit: reset to rst_val, otherwise apply the JK rule when enabled
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         q_q <= rst_val;
      end else if (en) begin
         q_q <= jk_next(j, k, q_q);
      end
   end

   assign q = q_q;

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops with per-bit JK control, parallel load and
// up/down counting. Counting is built from the same cells by toggling every
// bit whose lower bits are all ones (up) or all zeros (down).
// Optional feature: define JK_REG_BANK_TOGGLE_CNT_EN to add cnt_clr and a
// saturating toggle_cnt of changing edges; without it CNT_W is unused.
module jk_reg_bank
   import jk_pkg::*;
#(
   parameter int unsigned          WIDTH   = 4,
   parameter logic [WIDTH-1:0]     RST_VAL = '0,
   parameter int unsigned          CNT_W   = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             q_chg
`ifdef JK_REG_BANK_TOGGLE_CNT_EN
   ,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] toggle_cnt
`endif
);

   mode_e            mode_s;
   logic [WIDTH-1:0] j_cell;
   logic [WIDTH-1:0] k_cell;
   logic [WIDTH-1:0] q_w;
   logic [WIDTH-1:0] q_d;
   logic             chg_d;
   logic             q_chg_q;

   assign mode_s = mode_e'(mode);

   // Per-cell j/k derived from the mode; counting uses a ripple of all-ones/all-zeros
   always_comb begin
      logic carry;
      j_cell = j;
      k_cell = k;
      carry  = 1'b1;
      case (mode_s)
         MODE_LOAD: begin
            j_cell = d;
            k_cell = ~d;
         end
         MODE_UP: begin
            for (int i = 0; i < int'(WIDTH); i++) begin
               j_cell[i] = carry;
               k_cell[i] = carry;
               carry     = carry & q_w[i];
            end
         end
         MODE_DOWN: begin
            for (int i = 0; i < int'(WIDTH); i++) begin
               j_cell[i] = carry;
               k_cell[i] = carry;
               carry     = carry & ~q_w[i];
            end
         end
         default: begin
            j_cell = j;
            k_cell = k;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
         jk_ff_cell u_cell (
            .clk     (clk),
            .n_rst   (n_rst),
            .rst_val (RST_VAL[gi]),
            .en      (en),
            .j       (j_cell[gi]),
            .k       (k_cell[gi]),
            .q       (q_w[gi])
         );
      end
   endgenerate

   // Value the cells will take on the coming edge, used only to detect change
   always_comb begin
      q_d = q_w;
      for (int i = 0; i < int'(WIDTH); i++) begin
         q_d[i] = en ? jk_next(j_cell[i], k_cell[i], q_w[i]) : q_w[i];
      end
   end

   assign chg_d = (q_d != q_w);

   // Registered change flag: high for the one cycle after a changing edge
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         q_chg_q <= 1'b0;
      end else begin
         q_chg_q <= chg_d;
      end
   end

   assign q     = q_w;
   assign q_chg = q_chg_q;
   assign tc    = en && (((mode_s == MODE_UP)   && (q_w == {WIDTH{1'b1}})) ||
                         ((mode_s == MODE_DOWN) && (q_w == {WIDTH{1'b0}})));

`ifdef JK_REG_BANK_TOGGLE_CNT_EN
   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Saturating count of changing edges; clear wins over increment
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (chg_d && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Toggle counter register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign toggle_cnt = cnt_q;
`endif

endmodule
